acc_ctrl_seq: RTL
=================

Name: acc_ctrl_seq

Overview:
- Fetch/decode/execute sequencer for the 12-bit accumulator datapath.
- Generates every per-cycle strobe for the AC, R, PC, AR and IR registers and the ALU, plus the bus source select and the memory read/write handshake.
- Sits between the instruction register and the shared bus; the only block that drives AC enables.

Parameters:
- N, 12, datapath width; used only for the width of bus-facing constants.
- MEM_TO, 15, max cycles to wait for mem_ready before the timeout error.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE and begin fetching.
- ir_op  in  4  opcode field of IR, valid from DECODE onward.
- z_flag  in  1  AC==0, sampled in EXEC.
- mem_ready  in  1  memory completes the current rd/wr this cycle.
- bus_sel  out  4  bus source: 0 none, 1 PC, 2 MEM, 3 AC, 4 R, 5 IR-operand.
- ld_ar, ld_pc, inc_pc, ld_ir  out  1 each  register load strobes.
- mem_rd, mem_wr  out  1 each  memory request, held until mem_ready.
- ac_write_en, ac_inc_en, ac_clr_en, alu_to_ac  out  1 each  AC controls.
- ac_read_en  out  4  13 = R loads from bus; else 0.
- alu_op  out  3  0 ADD, 1 SUB, 2 AND; 0 when unused.
- halted  out  1  in HALT state.
- err  out  1  sticky: illegal opcode or memory timeout.
- instr_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- States: IDLE, FETCH1, FETCH2, DECODE, EXEC, EXEC_M, HALT, ERR.
- Reset (async): state=IDLE, instr_cnt=0, err=0, all strobes 0, bus_sel=0. Reset mid-memory-wait drops mem_rd/mem_wr immediately.
- Strobes are combinational from state, ir_op, z_flag and mem_ready. They are 0 in every state/cycle not listed below.
- IDLE: start=1 -> FETCH1.
- FETCH1: bus_sel=1, ld_ar=1 -> FETCH2.
- FETCH2: mem_rd=1 until mem_ready. In the mem_ready cycle: bus_sel=2, ld_ir=1, inc_pc=1 -> DECODE.
- DECODE: no strobes; instr_cnt+1 (wraps at 2^CNT_W) -> EXEC, HALT or ERR.
- EXEC, single-cycle opcodes (exactly one cycle, then FETCH1):
  - 0 NOP.
  - 1 CLAC: ac_clr_en.
  - 2 INAC: ac_inc_en.
  - 3 MVACR: bus_sel=3, ac_read_en=13.
  - 4 MVRAC: bus_sel=4, ac_write_en.
  - 5 ADD / 6 SUB / 7 AND: alu_op=0/1/2, alu_to_ac.
  - 10 JMP: bus_sel=5, ld_pc.
  - 11 JMPZ: as JMP if z_flag=1, else no strobes.
- EXEC, memory opcodes 8 LDAC / 9 STAC: bus_sel=5, ld_ar -> EXEC_M.
- EXEC_M:
  - LDAC: mem_rd until mem_ready; in that cycle bus_sel=2, ac_write_en.
  - STAC: bus_sel=3, mem_wr until mem_ready.
  - Then -> FETCH1.
- 15 HALT: DECODE -> HALT. halted=1, no strobes, start ignored; only reset exits.
- Opcodes 12-14 illegal: DECODE -> ERR; err=1, no strobes; only reset exits.
- Memory timeout: a wait counter clears on entering FETCH2/EXEC_M and increments each cycle without mem_ready. mem_ready in the same cycle the count reaches MEM_TO is accepted. One cycle later, if still not ready -> ERR, request dropped.
- Invariants:
  - At most one of ac_write_en, ac_inc_en, ac_clr_en, alu_to_ac per cycle.
  - mem_rd and mem_wr never both set.
  - bus_sel is non-zero whenever any bus-loading strobe is set.
- Latency with zero-wait memory:
  - Single-cycle instruction: 4 cycles.
  - LDAC/STAC: 5 cycles.

Test Plan:
- Reset then start, IR=2 (INAC), mem_ready tied 1 -> FETCH1 bus_sel=1 ld_ar; FETCH2 ld_ir+inc_pc; DECODE; EXEC ac_inc_en=1 for exactly 1 cycle; instr_cnt=1; next cycle FETCH1.
- LDAC with mem_ready delayed 3 cycles in EXEC_M -> mem_rd high 4 cycles; ac_write_en and bus_sel=2 only in the ready cycle; never concurrent with other AC strobes.
- JMPZ with z_flag=0, then z_flag=1 -> no ld_pc in the first case; ld_pc=1 with bus_sel=5 for one cycle in the second.
- mem_ready never asserted in FETCH2 -> mem_rd high MEM_TO+1=16 cycles, then ERR, err=1, strobes 0. Repeat with mem_ready on the 16th cycle -> no error, instruction completes.
- IR=15 -> halted=1, strobes 0, start pulses ignored. Assert rst_n=0 mid-HALT -> immediately IDLE, halted=0, instr_cnt=0.
- IR=13 -> err=1 after DECODE. Run 65536 NOPs in a separate run -> instr_cnt wraps to 0.

Source files
------------

// File: rtl/acc_ctrl_seq.sv
// Fetch/decode/execute sequencer for the 12-bit accumulator datapath.
// All strobes are combinational from state, ir_op, z_flag and mem_ready.
module acc_ctrl_seq #(
  parameter int N      = 12,
  parameter int MEM_TO = 15,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ir_op,
  input  logic             z_flag,
  input  logic             mem_ready,
  output logic [3:0]       bus_sel,
  output logic             ld_ar,
  output logic             ld_pc,
  output logic             inc_pc,
  output logic             ld_ir,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ac_write_en,
  output logic             ac_inc_en,
  output logic             ac_clr_en,
  output logic             alu_to_ac,
  output logic [3:0]       ac_read_en,
  output logic [2:0]       alu_op,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    IDLE, FETCH1, FETCH2, DECODE, EXEC, EXEC_M, HALT, ERR
  } state_t;

  // Bus source codes are datapath-width constants; only the low nibble leaves the block.
  localparam logic [N-1:0] BS_PC  = N'(1);
  localparam logic [N-1:0] BS_MEM = N'(2);
  localparam logic [N-1:0] BS_AC  = N'(3);
  localparam logic [N-1:0] BS_R   = N'(4);
  localparam logic [N-1:0] BS_OPN = N'(5);

  localparam logic [3:0] OP_NOP = 4'd0, OP_CLAC = 4'd1, OP_INAC = 4'd2, OP_MVACR = 4'd3,
                         OP_MVRAC = 4'd4, OP_ADD = 4'd5, OP_SUB = 4'd6, OP_AND = 4'd7,
                         OP_LDAC = 4'd8, OP_STAC = 4'd9, OP_JMP = 4'd10, OP_JMPZ = 4'd11,
                         OP_HALT = 4'd15;

  localparam int WC_W = (MEM_TO < 1) ? 1 : $clog2(MEM_TO + 1);

  state_t          state_q, state_d;
  logic [WC_W-1:0] wait_cnt;
  logic            timeout;

  assign timeout = (wait_cnt == WC_W'(MEM_TO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      instr_cnt <= '0;
      err       <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) instr_cnt <= instr_cnt + CNT_W'(1);
      if (state_d == ERR) err <= 1'b1;
      // Every path into a wait state passes through a non-wait state, so clearing here is "clear on entry".
      if (state_q == FETCH2 || state_q == EXEC_M) begin
        if (!mem_ready) wait_cnt <= wait_cnt + WC_W'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    bus_sel     = 4'd0;
    ld_ar       = 1'b0;
    ld_pc       = 1'b0;
    inc_pc      = 1'b0;
    ld_ir       = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    ac_write_en = 1'b0;
    ac_inc_en   = 1'b0;
    ac_clr_en   = 1'b0;
    alu_to_ac   = 1'b0;
    ac_read_en  = 4'd0;
    alu_op      = 3'd0;
    halted      = (state_q == HALT);
    case (state_q)
      IDLE:   if (start) state_d = FETCH1;
      FETCH1: begin
        bus_sel = BS_PC[3:0];
        ld_ar   = 1'b1;
        state_d = FETCH2;
      end
      FETCH2: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          bus_sel = BS_MEM[3:0];
          ld_ir   = 1'b1;
          inc_pc  = 1'b1;
          state_d = DECODE;
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      DECODE: begin
        case (ir_op)
          OP_HALT:             state_d = HALT;
          4'd12, 4'd13, 4'd14: state_d = ERR;
          default:             state_d = EXEC;
        endcase
      end
      EXEC: begin
        state_d = FETCH1;
        case (ir_op)
          OP_CLAC:  ac_clr_en = 1'b1;
          OP_INAC:  ac_inc_en = 1'b1;
          OP_MVACR: begin bus_sel = BS_AC[3:0]; ac_read_en = 4'd13; end
          OP_MVRAC: begin bus_sel = BS_R[3:0]; ac_write_en = 1'b1; end
          OP_ADD:   begin alu_op = 3'd0; alu_to_ac = 1'b1; end
          OP_SUB:   begin alu_op = 3'd1; alu_to_ac = 1'b1; end
          OP_AND:   begin alu_op = 3'd2; alu_to_ac = 1'b1; end
          OP_LDAC, OP_STAC: begin
            bus_sel = BS_OPN[3:0];
            ld_ar   = 1'b1;
            state_d = EXEC_M;
          end
          OP_JMP:   begin bus_sel = BS_OPN[3:0]; ld_pc = 1'b1; end
          OP_JMPZ:  if (z_flag) begin bus_sel = BS_OPN[3:0]; ld_pc = 1'b1; end
          default:  ;
        endcase
      end
      EXEC_M: begin
        if (ir_op == OP_STAC) begin
          bus_sel = BS_AC[3:0];
          mem_wr  = 1'b1;
        end else begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            bus_sel     = BS_MEM[3:0];
            ac_write_en = 1'b1;
          end
        end
        if (mem_ready)    state_d = FETCH1;
        else if (timeout) state_d = ERR;
      end
      HALT:    ;
      ERR:     ;
      default: state_d = IDLE;
    endcase
  end

endmodule
